par2ser_bitstream: RTL and testbench

Parallel-to-serial front end for the serial sequence-detector stage. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per cycle as ser_bit/ser_valid. A one-word holding buffer lets back-to-back words stream with no idle bit between them. Optional inter-word gap cycles and a downstream stall input are supported.

---
 rtl/par2ser_bitstream.sv | 154 +++++++++++++++
 tb/tb_par2ser_bitstream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/par2ser_bitstream.sv
// Parallel-to-serial converter: WIDTH-bit words in over valid/ready, one bit per cycle out.
// Latency: a word accepted at edge N presents its first bit in cycle N+1; back-to-back words stream with no bubble.
// Backpressure: one-word holding buffer; in_ready drops while it is full; stall freezes the serial output.
module par2ser_bitstream #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_sof,
    output logic             ser_eof,
    output logic             busy,
    output logic [15:0]      word_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [4:0] LAST     = 5'(WIDTH - 1);
    localparam logic [3:0] GAP_INIT = 4'((GAP > 0) ? (GAP - 1) : 0);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [4:0]         bcnt_q, bcnt_d;
    logic [3:0]         gcnt_q, gcnt_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [15:0]        wcnt_q, wcnt_d;
    logic               accept;
    logic               load_hold;
    logic               load_in;

    assign in_ready   = !reset && !hold_full_q;
    assign accept     = in_valid && in_ready;

    assign ser_valid  = (state_q == S_SHIFT);
    assign ser_bit    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign ser_sof    = (state_q == S_SHIFT) && (bcnt_q == 5'd0);
    assign ser_eof    = (state_q == S_SHIFT) && (bcnt_q == LAST);
    assign busy       = (state_q != S_IDLE) || hold_full_q;
    assign word_count = wcnt_q;

    // Next-state: shifting, hold-buffer fill/drain, gap timing and word loading.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        gcnt_d      = gcnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        wcnt_d      = wcnt_q;
        load_hold   = 1'b0;
        load_in     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Idle words skip the hold buffer so the first bit appears next cycle.
                if (accept) begin
                    load_in = 1'b1;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    hold_d      = in_data;
                    hold_full_d = 1'b1;
                end
                if (!stall) begin
                    if (bcnt_q != LAST) begin
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                        bcnt_d  = bcnt_q + 5'd1;
                    end else begin
                        wcnt_d = wcnt_q + 16'd1;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gcnt_d  = GAP_INIT;
                        end else if (hold_full_q) begin
                            load_hold = 1'b1;
                        end else if (accept) begin
                            // Word arriving on the last bit goes straight in: no bubble.
                            load_in     = 1'b1;
                            hold_full_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (accept) begin
                    hold_d      = in_data;
                    hold_full_d = 1'b1;
                end
                if (gcnt_q != 4'd0) begin
                    gcnt_d = gcnt_q - 4'd1;
                end else if (hold_full_q) begin
                    load_hold = 1'b1;
                end else if (accept) begin
                    load_in     = 1'b1;
                    hold_full_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Hold only loads when full, and in_ready is low then, so no accept collides with it.
        if (load_hold) begin
            shreg_d     = hold_q;
            bcnt_d      = 5'd0;
            state_d     = S_SHIFT;
            hold_full_d = 1'b0;
        end
        if (load_in) begin
            shreg_d = in_data;
            bcnt_d  = 5'd0;
            state_d = S_SHIFT;
        end
    end

    // State register; reset discards any partial and held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            bcnt_q      <= '0;
            gcnt_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            wcnt_q      <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_par2ser_bitstream.sv
// Bench for par2ser_bitstream: two instances (MSB-first/no gap, LSB-first/gap of 2).
// Word-level reference model: accepted words are queued, the monitor walks their bits.
// Checks bit order, sof/eof, latency, gap length, in_ready, busy, word_count, stall and reset.
module tb_par2ser_bitstream;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data    [2];
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic        stall      [2];
    logic        ser_bit    [2];
    logic        ser_valid  [2];
    logic        ser_sof    [2];
    logic        ser_eof    [2];
    logic        busy       [2];
    logic [15:0] word_count [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state per instance
    logic [7:0] wq [2][$];
    int pos [2];
    int exp_wc [2];
    int gap_left [2];
    bit lat_chk [2];
    bit waiting [2];
    bit known [2];
    int idle [2];
    int vcnt [2];
    int last_cycles [2];
    bit done;

    always #5 clk = ~clk;

    par2ser_bitstream #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .stall(stall[0]), .ser_bit(ser_bit[0]),
        .ser_valid(ser_valid[0]), .ser_sof(ser_sof[0]), .ser_eof(ser_eof[0]),
        .busy(busy[0]), .word_count(word_count[0])
    );

    par2ser_bitstream #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .stall(stall[1]), .ser_bit(ser_bit[1]),
        .ser_valid(ser_valid[1]), .ser_sof(ser_sof[1]), .ser_eof(ser_eof[1]),
        .busy(busy[1]), .word_count(word_count[1])
    );

    function automatic int gap_of(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic int exp_bit(int k, logic [7:0] w, int p);
        return (k == 0) ? int'(w[7-p]) : int'(w[p]);
    endfunction

    task automatic check(string nm, int k, int act, int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s[dut%0d] at %0t: got %0d expected %0d", nm, k, $time, act, expv);
        end
    endtask

    // One negedge of model + comparison for instance k
    task automatic monitor_one(int k);
        bit acc;
        bit xfer;
        acc  = in_valid[k] && in_ready[k];
        xfer = ser_valid[k] && !stall[k];

        check("word_count", k, int'(word_count[k]), exp_wc[k] & 16'hFFFF);
        check("busy", k, int'(busy[k]), int'(wq[k].size() > 0 || gap_left[k] > 0));
        check("in_ready", k, int'(in_ready[k]),
              int'(wq[k].size() < ((gap_left[k] > 0) ? 1 : 2)));
        if (lat_chk[k]) begin
            check("first_bit_latency", k, int'(ser_valid[k]), 1);
            lat_chk[k] = 1'b0;
        end
        if (ser_valid[k]) begin
            if (wq[k].size() == 0) begin
                check("spurious_valid", k, 1, 0);
            end else begin
                check("ser_bit", k, int'(ser_bit[k]), exp_bit(k, wq[k][0], pos[k]));
                check("ser_sof", k, int'(ser_sof[k]), int'(pos[k] == 0));
                check("ser_eof", k, int'(ser_eof[k]), int'(pos[k] == 7));
            end
            vcnt[k]++;
        end
        if (waiting[k]) begin
            if (ser_valid[k]) begin
                if (known[k]) check("gap_exact", k, idle[k], gap_of(k));
                else          check("gap_min", k, int'(idle[k] >= gap_of(k)), 1);
                waiting[k] = 1'b0;
            end else begin
                idle[k]++;
            end
        end

        if (gap_left[k] > 0) gap_left[k]--;
        if (xfer && wq[k].size() > 0) begin
            pos[k]++;
            if (pos[k] == 8) begin
                pos[k] = 0;
                void'(wq[k].pop_front());
                exp_wc[k]++;
                gap_left[k] = gap_of(k);
                waiting[k] = 1'b1;
                idle[k] = 0;
                known[k] = (wq[k].size() > 0) || acc;
                last_cycles[k] = vcnt[k];
                vcnt[k] = 0;
            end
        end
        if (acc) begin
            lat_chk[k] = (wq[k].size() == 0) && (gap_left[k] == 0);
            wq[k].push_back(in_data[k]);
        end
    endtask

    // Monitor: compare every cycle on the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                wq[k].delete();
                pos[k] = 0; exp_wc[k] = 0; gap_left[k] = 0; lat_chk[k] = 1'b0;
                waiting[k] = 1'b0; idle[k] = 0; vcnt[k] = 0;
            end else begin
                monitor_one(k);
            end
        end
    end

    task automatic send(int k, logic [7:0] w, int pre_idle);
        bit acc;
        int budget;
        in_valid[k] = 1'b0;
        repeat (pre_idle) begin @(posedge clk); #1; end
        in_valid[k] = 1'b1;
        in_data[k]  = w;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 300) begin
            @(negedge clk);
            acc = in_ready[k];
            @(posedge clk); #1;
            budget++;
        end
        in_valid[k] = 1'b0;
        if (!acc) check("accept_timeout", k, 0, 1);
    endtask

    task automatic wait_idle(int k);
        int budget;
        budget = 0;
        do begin
            @(posedge clk); #1;
            budget++;
        end while ((wq[k].size() > 0 || gap_left[k] > 0) && budget < 2000);
        if (budget >= 2000) check("drain_timeout", k, 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        reset = 1'b1;
        done  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_data[k] = '0; stall[k] = 1'b0;
            last_cycles[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ser_valid", k, int'(ser_valid[k]), 0);
            check("rst_ser_bit", k, int'(ser_bit[k]), 0);
            check("rst_in_ready", k, int'(in_ready[k]), 0);
            check("rst_busy", k, int'(busy[k]), 0);
            check("rst_word_count", k, int'(word_count[k]), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Single words: MSB-first 0xE8 and LSB-first 0x17
        send(0, 8'hE8, 1);
        wait_idle(0);
        check("word_cycles_plain", 0, last_cycles[0], 8);
        send(1, 8'h17, 1);
        wait_idle(1);
        check("word_cycles_plain", 1, last_cycles[1], 8);

        // Streaming with in_valid held high
        send(0, 8'hE8, 0);
        send(0, 8'h1D, 0);
        send(0, 8'hFF, 0);
        wait_idle(0);
        check("stream_count", 0, int'(word_count[0]), 4);
        send(1, 8'hA5, 0);
        send(1, 8'h3C, 0);
        wait_idle(1);

        // Stall for 3 cycles while bit index 2 is presented
        send(0, 8'hE8, 0);
        budget = 0;
        while (pos[0] != 2 && budget < 50) begin @(posedge clk); #1; budget++; end
        if (budget >= 50) check("stall_setup_timeout", 0, 0, 1);
        stall[0] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        stall[0] = 1'b0;
        wait_idle(0);
        check("word_cycles_stalled", 0, last_cycles[0], 11);

        // Randomized traffic on both instances with random stalls
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 60; i++) send(0, 8'($urandom), $urandom_range(0, 3));
                    end
                    begin
                        for (int i = 0; i < 60; i++) send(1, 8'($urandom), $urandom_range(0, 3));
                    end
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    stall[0] = ($urandom_range(0, 3) == 0);
                    stall[1] = ($urandom_range(0, 3) == 0);
                end
                stall[0] = 1'b0;
                stall[1] = 1'b0;
            end
        join
        wait_idle(0);
        wait_idle(1);

        // Reset mid-word with the holding buffer full
        send(0, 8'hA5, 0);
        send(0, 8'h3C, 0);
        budget = 0;
        while (!(pos[0] == 4 && wq[0].size() == 2) && budget < 50) begin
            @(posedge clk); #1; budget++;
        end
        if (budget >= 50) check("reset_setup_timeout", 0, 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_ser_valid", 0, int'(ser_valid[0]), 0);
        check("midrst_in_ready", 0, int'(in_ready[0]), 0);
        check("midrst_word_count", 0, int'(word_count[0]), 0);
        check("midrst_busy", 0, int'(busy[0]), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", 0, int'(in_ready[0]), 1);
        check("postrst_in_ready", 1, int'(in_ready[1]), 1);
        repeat (20) @(posedge clk);
        #1;
        send(0, 8'h81, 0);
        wait_idle(0);
        check("postrst_count", 0, int'(word_count[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
